int_arbiter: RTL and testbench
==============================

INT_ARBITER -- requirements
Module: int_arbiter

Interface
REQ-001 Parameter NSRC, default 4, number of interrupt sources (2..8).
REQ-002 Parameter ID_W, default 3, claim-ID width, SHALL be at least clog2(NSRC+1).
REQ-003 Port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 Port rstn, input, 1, asynchronous active-low reset.
REQ-005 Port src_i, input, NSRC, raw interrupt lines, already synchronous to clk.
REQ-006 Port enable_i, input, NSRC, per-source enable mask; 1 = eligible.
REQ-007 Port int_req_o, output, 1, interrupt request to CPU.
REQ-008 Port int_id_o, output, ID_W, claimed ID: source index+1; 0 = none.
REQ-009 Port int_ack_i, input, 1, CPU takes the request (claim).
REQ-010 Port complete_i, input, 1, CPU finished the handler (mret).
REQ-011 Port pending_o, output, NSRC, current pending bits.
REQ-012 Port busy_o, output, 1, high while in REQ or SERVICE.

Function
REQ-013 SHALL register src_i each cycle; rising edge = src_i[k]=1 with previous sample 0.
REQ-014 pending[k] SHALL set after the edge on which a rising edge of src_i[k] is sampled, regardless of enable_i.
REQ-015 pending[k] SHALL clear on the int_ack_i cycle in REQ when int_id_o = k+1; a same-cycle new rising edge on k wins (pending stays 1).
REQ-016 FSM states: IDLE, REQ, SERVICE; reset state IDLE.
REQ-017 IDLE -> REQ when (pending & enable_i) != 0; winner latched into int_id_o at that edge.
REQ-018 REQ: int_req_o=1, int_id_o stable until ack; SHALL NOT withdraw or change ID if enable_i or src_i drop.
REQ-019 REQ -> SERVICE on int_ack_i=1; int_req_o=0 from the next cycle.
REQ-020 SERVICE -> IDLE on complete_i=1; int_id_o returns to 0 in IDLE.
REQ-021 complete_i in IDLE or REQ, and int_ack_i outside REQ, SHALL be ignored.
REQ-022 Latency: rising edge sampled at edge n -> pending at n -> int_req_o high after edge n+1 (from IDLE, source enabled).
REQ-023 After complete_i at edge m, a still-pending enabled source SHALL raise int_req_o after edge m+1 (one IDLE cycle minimum).
REQ-024 Default winner selection: fixed priority, lowest index highest.
REQ-025 No nesting: new edges during REQ/SERVICE only set pending.
REQ-026 busy_o = (state != IDLE); pending_o = pending register, combinational from state only.

Reset
REQ-027 On rstn=0: state IDLE, pending=0, src sample register=0, int_id_o=0, int_req_o=0, busy_o=0, pending_o=0.
REQ-028 Reset mid-REQ or mid-SERVICE SHALL abandon the claim immediately with no completion required.
REQ-029 A source held high through reset release SHALL register a rising edge on the first clock (sample register is 0).

Configuration
REQ-030 Macro INT_ARB_RR_EN: when defined, winner is round-robin; search starts at last-acked index+1, wrapping at NSRC.
REQ-031 With INT_ARB_RR_EN, the pointer updates only on int_ack_i in REQ; reset value NSRC-1 (index 0 searched first).
REQ-032 Without INT_ARB_RR_EN, fixed priority per REQ-024 and no pointer register exists.

Verification
REQ-033 src_i=4'b0010 rising, enable_i=4'hF -> pending_o=4'b0010, int_req_o=1 with int_id_o=2 one cycle later; ack -> pending_o=0, busy_o=1.
REQ-034 src_i edges on 0 and 2 same cycle, fixed priority -> ID 1 claimed first; after complete_i, ID 3 requested after one IDLE cycle.
REQ-035 INT_ARB_RR_EN, sources 0 and 1 re-pulse after every completion -> grant IDs alternate 1,2,1,2.
REQ-036 enable_i=4'b1110, edge on source 0 -> pending_o=4'b0001, int_req_o stays 0; set enable_i[0]=1 -> int_req_o=1, int_id_o=1 next cycle.
REQ-037 In REQ with int_id_o=3, drop enable_i[2] and pulse complete_i -> int_req_o and int_id_o=3 held until int_ack_i.
REQ-038 Assert rstn=0 during SERVICE -> all outputs 0 asynchronously; src_i[1] held high at release -> int_id_o=2 requested.

Source files
------------

// File: rtl/int_arbiter.sv
// rtl/int_arbiter.sv - interrupt arbiter: edge-detected pending bits, single-claim REQ/SERVICE handshake
//
// Optional feature macro: INT_ARB_RR_EN (round-robin winner selection; default is fixed priority)
//
// Ports:
//   clk         sole clock, rising edge
//   rstn        asynchronous active-low reset
//   src_i       raw interrupt lines, synchronous to clk
//   enable_i    per-source eligibility mask
//   int_req_o   interrupt request to CPU (high in REQ)
//   int_id_o    claimed source index+1, 0 when idle
//   int_ack_i   CPU claims the request (honoured only in REQ)
//   complete_i  CPU handler finished (honoured only in SERVICE)
//   pending_o   pending register
//   busy_o      high while a claim is in progress (REQ or SERVICE)
module int_arbiter #(
  parameter int NSRC = 4,
  parameter int ID_W = 3
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NSRC-1:0] src_i,
  input  logic [NSRC-1:0] enable_i,
  output logic            int_req_o,
  output logic [ID_W-1:0] int_id_o,
  input  logic            int_ack_i,
  input  logic            complete_i,
  output logic [NSRC-1:0] pending_o,
  output logic            busy_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] clr_mask;
  logic [ID_W-1:0] id_q, id_d;
  logic [ID_W-1:0] win_idx;
  logic            ack_take;

  // First set bit of elig, scanning upward from index start and wrapping at NSRC.
  function automatic logic [ID_W-1:0] pick_first(input logic [NSRC-1:0] elig, input int start);
    logic [ID_W-1:0] r;
    logic            found;
    logic [NSRC-1:0] sh;
    int              k;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      k  = (start + i) % NSRC;
      sh = elig >> k;
      if (!found && sh[0]) begin
        found = 1'b1;
        r     = ID_W'(k);
      end
    end
    return r;
  endfunction

  assign rise     = src_i & ~src_q;
  assign eligible = pending_q & enable_i;
  assign ack_take = (state_q == S_REQ) && int_ack_i;

  // A new rising edge on the acked source in the same cycle keeps it pending.
  assign clr_mask  = ack_take ? (NSRC'(1) << (id_q - ID_W'(1))) : '0;
  assign pending_d = (pending_q & ~clr_mask) | rise;

`ifdef INT_ARB_RR_EN
  // Index of the last acked source; reset value makes index 0 the first searched.
  logic [ID_W-1:0] ptr_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= ID_W'(NSRC - 1);
    end else if (ack_take) begin
      ptr_q <= id_q - ID_W'(1);
    end
  end

  assign win_idx = pick_first(eligible, int'(ptr_q) + 1);
`else
  assign win_idx = pick_first(eligible, 0);
`endif

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      S_IDLE: begin
        if (eligible != '0) begin
          state_d = S_REQ;
          id_d    = win_idx + ID_W'(1);
        end
      end
      S_REQ: begin
        // ID is frozen here even if the source or its enable drops.
        if (int_ack_i) begin
          state_d = S_SERVICE;
        end
      end
      S_SERVICE: begin
        if (complete_i) begin
          state_d = S_IDLE;
          id_d    = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        id_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      pending_q <= '0;
      id_q      <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_i;
      pending_q <= pending_d;
      id_q      <= id_d;
    end
  end

  assign int_req_o = (state_q == S_REQ);
  assign busy_o    = (state_q != S_IDLE);
  assign int_id_o  = id_q;
  assign pending_o = pending_q;

endmodule

// File: tb/tb_int_arbiter.sv
// tb/tb_int_arbiter.sv - self-checking bench for int_arbiter with a behavioural reference model
module tb_int_arbiter;
  localparam int NSRC = 4;
  localparam int ID_W = 3;

  logic            clk = 1'b0;
  logic            rstn;
  logic [NSRC-1:0] src;
  logic [NSRC-1:0] en;
  logic            ack;
  logic            cmp;
  logic            int_req_o;
  logic [ID_W-1:0] int_id_o;
  logic [NSRC-1:0] pending_o;
  logic            busy_o;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 requesting, 2 servicing
  int              m_state;
  int              m_id;
  int              m_ptr;
  bit [NSRC-1:0]   m_pend;
  bit [NSRC-1:0]   m_prev;

  always #5 clk = ~clk;

  int_arbiter #(.NSRC(NSRC), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .src_i      (src),
    .enable_i   (en),
    .int_req_o  (int_req_o),
    .int_id_o   (int_id_o),
    .int_ack_i  (ack),
    .complete_i (cmp),
    .pending_o  (pending_o),
    .busy_o     (busy_o)
  );

  function automatic int m_pick(bit [NSRC-1:0] elig, int start);
    int k;
    for (int i = 0; i < NSRC; i++) begin
      k = (start + i) % NSRC;
      if (elig[k]) return k;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_state = 0;
    m_id    = 0;
    m_ptr   = NSRC - 1;
    m_pend  = '0;
    m_prev  = '0;
  endtask

  // One clock: model computes from the inputs present before the edge; returns at the next falling edge.
  task automatic tick();
    bit [NSRC-1:0] rise, clr;
    int nstate, nid, start;
    rise   = src & ~m_prev;
    clr    = '0;
    nstate = m_state;
    nid    = m_id;
    case (m_state)
      0: if ((m_pend & en) != 0) begin
`ifdef INT_ARB_RR_EN
        start = m_ptr + 1;
`else
        start = 0;
`endif
        nstate = 1;
        nid    = m_pick(m_pend & en, start) + 1;
      end
      1: if (ack) begin
        nstate       = 2;
        clr[m_id-1]  = 1'b1;
        m_ptr        = m_id - 1;
      end
      default: if (cmp) begin
        nstate = 0;
        nid    = 0;
      end
    endcase
    @(posedge clk);
    m_pend  = (m_pend & ~clr) | rise;
    m_prev  = src;
    m_state = nstate;
    m_id    = nid;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0; src = '0; en = '1; ack = 1'b0; cmp = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    checks++; if (int_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", int_req_o); end
    checks++; if (int_id_o !== '0) begin errors++; $display("FAIL reset_id: got %0d expected 0", int_id_o); end
    checks++; if (pending_o !== '0) begin errors++; $display("FAIL reset_pending: got %b expected 0000", pending_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    src = 4'b0010; en = 4'hF;
    tick();
    checks++; if (pending_o !== 4'b0010) begin errors++; $display("FAIL basic_pending: got %b expected 0010", pending_o); end
    checks++; if (int_req_o !== 1'b0) begin errors++; $display("FAIL basic_req_early: got %b expected 0", int_req_o); end
    src = '0;
    tick();
    checks++; if (int_req_o !== 1'b1 || int_id_o !== 3'd2) begin errors++; $display("FAIL basic_req: got req=%b id=%0d expected req=1 id=2", int_req_o, int_id_o); end
    ack = 1'b1; tick(); ack = 1'b0;
    checks++; if (pending_o !== 4'b0000 || busy_o !== 1'b1 || int_req_o !== 1'b0) begin errors++; $display("FAIL basic_ack: got pend=%b busy=%b req=%b expected 0000 1 0", pending_o, busy_o, int_req_o); end
    ack = 1'b1; tick(); ack = 1'b0;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL basic_ack_in_service: got busy=%b expected 1", busy_o); end
    cmp = 1'b1; tick(); cmp = 1'b0;
    checks++; if (busy_o !== 1'b0 || int_id_o !== '0) begin errors++; $display("FAIL basic_complete: got busy=%b id=%0d expected 0 0", busy_o, int_id_o); end
  endtask

  task automatic test_priority();
    src = 4'b0101; tick(); src = '0;
    tick();
    checks++; if (int_id_o !== 3'd1) begin errors++; $display("FAIL prio_first: got id=%0d expected 1", int_id_o); end
    ack = 1'b1; tick(); ack = 1'b0;
    cmp = 1'b1; tick(); cmp = 1'b0;
    checks++; if (int_req_o !== 1'b0 || pending_o !== 4'b0100) begin errors++; $display("FAIL prio_idle_gap: got req=%b pend=%b expected 0 0100", int_req_o, pending_o); end
    tick();
    checks++; if (int_req_o !== 1'b1 || int_id_o !== 3'd3) begin errors++; $display("FAIL prio_second: got req=%b id=%0d expected 1 3", int_req_o, int_id_o); end
    ack = 1'b1; tick(); ack = 1'b0;
    cmp = 1'b1; tick(); cmp = 1'b0;
  endtask

  task automatic test_rr();
    int exp_id;
    test_reset();
    for (int i = 0; i < 4; i++) begin
      src = 4'b0011; tick(); src = '0;
      tick();
      exp_id = (i % 2) + 1;
      checks++; if (int_req_o !== 1'b1 || int_id_o !== ID_W'(exp_id)) begin errors++; $display("FAIL rr_grant%0d: got req=%b id=%0d expected 1 %0d", i, int_req_o, int_id_o, exp_id); end
      ack = 1'b1; tick(); ack = 1'b0;
      cmp = 1'b1; tick(); cmp = 1'b0;
    end
    // Drain the remaining pending source.
    tick(); ack = 1'b1; tick(); ack = 1'b0; cmp = 1'b1; tick(); cmp = 1'b0;
  endtask

  task automatic test_enable_mask();
    en = 4'b1110; src = 4'b0001; tick(); src = '0;
    checks++; if (pending_o !== 4'b0001) begin errors++; $display("FAIL mask_pending: got %b expected 0001", pending_o); end
    repeat (3) tick();
    checks++; if (int_req_o !== 1'b0) begin errors++; $display("FAIL mask_no_req: got %b expected 0", int_req_o); end
    en = 4'hF; tick();
    checks++; if (int_req_o !== 1'b1 || int_id_o !== 3'd1) begin errors++; $display("FAIL mask_enable: got req=%b id=%0d expected 1 1", int_req_o, int_id_o); end
    ack = 1'b1; tick(); ack = 1'b0;
    cmp = 1'b1; tick(); cmp = 1'b0;
  endtask

  task automatic test_hold();
    src = 4'b0100; tick(); tick();
    checks++; if (int_id_o !== 3'd3) begin errors++; $display("FAIL hold_setup: got id=%0d expected 3", int_id_o); end
    en = 4'b1011; src = '0; cmp = 1'b1; tick(); cmp = 1'b0;
    repeat (2) tick();
    checks++; if (int_req_o !== 1'b1 || int_id_o !== 3'd3) begin errors++; $display("FAIL hold_req: got req=%b id=%0d expected 1 3", int_req_o, int_id_o); end
    ack = 1'b1; tick(); ack = 1'b0; en = 4'hF;
    checks++; if (int_req_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL hold_ack: got req=%b busy=%b expected 0 1", int_req_o, busy_o); end
    cmp = 1'b1; tick(); cmp = 1'b0;
  endtask

  task automatic test_async_reset();
    src = 4'b0010; tick(); tick();
    ack = 1'b1; tick(); ack = 1'b0;
    #2 rstn = 1'b0;
    #1;
    m_reset();
    checks++; if (busy_o !== 1'b0 || int_req_o !== 1'b0 || int_id_o !== '0 || pending_o !== '0) begin errors++; $display("FAIL areset_outputs: got busy=%b req=%b id=%0d pend=%b expected all 0", busy_o, int_req_o, int_id_o, pending_o); end
    @(negedge clk);
    rstn = 1'b1;
    tick();
    checks++; if (pending_o !== 4'b0010) begin errors++; $display("FAIL areset_held_edge: got pend=%b expected 0010", pending_o); end
    tick();
    checks++; if (int_req_o !== 1'b1 || int_id_o !== 3'd2) begin errors++; $display("FAIL areset_req: got req=%b id=%0d expected 1 2", int_req_o, int_id_o); end
    src = '0;
    ack = 1'b1; tick(); ack = 1'b0;
    cmp = 1'b1; tick(); cmp = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      src = NSRC'($urandom_range(0, 15) & $urandom_range(0, 15));
      en  = NSRC'($urandom_range(0, 15) | (($urandom_range(0, 3) == 0) ? 0 : 15));
      ack = ($urandom_range(0, 2) == 0);
      cmp = ($urandom_range(0, 2) == 0);
      tick();
      checks++;
      if (int_req_o !== (m_state == 1) || busy_o !== (m_state != 0) ||
          int_id_o !== ID_W'(m_id) || pending_o !== m_pend) begin
        errors++;
        $display("FAIL random_step%0d: got req=%b busy=%b id=%0d pend=%b expected req=%b busy=%b id=%0d pend=%b",
                 i, int_req_o, busy_o, int_id_o, pending_o, m_state == 1, m_state != 0, m_id, m_pend);
      end
    end
    src = '0; en = 4'hF; ack = 1'b0; cmp = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
`ifdef INT_ARB_RR_EN
    test_rr();
`else
    test_priority();
`endif
    test_enable_mask();
    test_hold();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
